vga_scanout_reader: RTL and testbench

- Read side of the 160x120, 3-bit-colour frame buffer that pixel writers fill through the VGA adapter's x/y/colour/plot port.
- Generates 640x480@60 Hz VGA timing from the 50 MHz clock and computes frame-buffer read addresses with 4x pixel replication.
- Fetches each pixel from a synchronous-read RAM port and drives the DAC/sync pins with pipeline-aligned timing.

---
 rtl/vga_scanout_reader.sv | 177 +++++++++++++++++
 tb/tb_vga_scanout_reader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanout_reader
// Purpose  : Read side of a 160x120, 3-bit colour frame buffer. Generates
//            640x480@60 Hz timing from a 50 MHz clock with a 25 MHz pixel
//            tick. Issues one synchronous RAM read per pixel with 4x pixel
//            replication. Drives DAC colour and sync pins with matching
//            pipeline delay.
// Ports    : clock, reset       - 50 MHz clock, synchronous active-high reset
//            rd_addr, rd_en     - frame-buffer read address and strobe
//            rd_data            - RAM data {R,G,B}, valid one clock after rd_en
//            VGA_R/G/B          - 10-bit DAC colour, each bit replicated
//            VGA_HS, VGA_VS     - active-low syncs
//            VGA_BLANK          - high in the visible region only
//            VGA_SYNC           - tied low
//            VGA_CLK            - 25 MHz DAC clock, rising mid-pixel
//            frame_start        - one-clock pulse when the scan is at (0,0)
// Revision : 1.0 - initial release
// ============================================================================
module vga_scanout_reader #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int FB_WIDTH    = 160,
  parameter int SCALE_SHIFT = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [14:0] rd_addr,
  output logic        rd_en,
  input  logic [2:0]  rd_data,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK,
  output logic        VGA_SYNC,
  output logic        VGA_CLK,
  output logic        frame_start
);

  localparam logic [9:0] C_H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] C_H_SS    = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] C_H_SE    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] C_H_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] C_V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] C_V_SS    = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] C_V_SE    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] C_V_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  // Row stride multiply split into two shifts. FB_WIDTH must be a sum of two
  // powers of two. For 160 this gives 128 + 32, i.e. shifts of 7 and 5.
  localparam int         C_SH_HI   = $clog2(FB_WIDTH) - 1;
  localparam int         C_SH_LO   = $clog2(FB_WIDTH - (1 << C_SH_HI));

  logic        pix_en_q, pix_en_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        rd_en_q, rd_en_d;
  logic [14:0] rd_addr_q, rd_addr_d;
  logic        frame_start_q, frame_start_d;
  logic        vis1_q, vis1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [9:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic        vga_clk_q, vga_clk_d;

  logic        w_h_last, w_v_last, w_vis, w_hs, w_vs, w_origin;
  logic [14:0] w_row, w_col, w_addr;

  assign w_h_last = (h_cnt_q == C_H_LAST);
  assign w_v_last = (v_cnt_q == C_V_LAST);
  assign w_vis    = (h_cnt_q < C_H_VIS) && (v_cnt_q < C_V_VIS);
  assign w_hs     = !((h_cnt_q >= C_H_SS) && (h_cnt_q < C_H_SE));
  assign w_vs     = !((v_cnt_q >= C_V_SS) && (v_cnt_q < C_V_SE));
  assign w_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign w_row    = 15'(v_cnt_q >> SCALE_SHIFT);
  assign w_col    = 15'(h_cnt_q >> SCALE_SHIFT);
  assign w_addr   = (w_row << C_SH_HI) + (w_row << C_SH_LO) + w_col;

  always_comb begin
    pix_en_d      = ~pix_en_q;
    vga_clk_d     = ~pix_en_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    rd_en_d       = 1'b0;
    rd_addr_d     = rd_addr_q;
    frame_start_d = 1'b0;
    vis1_d        = vis1_q;
    hs1_d         = hs1_q;
    vs1_d         = vs1_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_d       = blank_q;
    if (pix_en_q) begin
      h_cnt_d = w_h_last ? '0 : h_cnt_q + 10'd1;
      if (w_h_last) begin
        v_cnt_d = w_v_last ? '0 : v_cnt_q + 10'd1;
      end
      // Stage 0: issue the read. The address holds during blanking.
      rd_en_d       = w_vis;
      frame_start_d = w_origin;
      if (w_vis) begin
        rd_addr_d = w_addr;
      end
      vis1_d = w_vis;
      hs1_d  = w_hs;
      vs1_d  = w_vs;
      // Stage 2: RAM data returned on the intervening non-tick clock is
      // aligned with the stage-1 controls captured on the previous tick.
      r_d     = vis1_q ? {10{rd_data[2]}} : '0;
      g_d     = vis1_q ? {10{rd_data[1]}} : '0;
      b_d     = vis1_q ? {10{rd_data[0]}} : '0;
      hs_d    = hs1_q;
      vs_d    = vs1_q;
      blank_d = vis1_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pix_en_q      <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      frame_start_q <= 1'b0;
      vis1_q        <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      vga_clk_q     <= 1'b0;
    end else begin
      pix_en_q      <= pix_en_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      frame_start_q <= frame_start_d;
      vis1_q        <= vis1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      vga_clk_q     <= vga_clk_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign frame_start = frame_start_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK   = blank_q;
  assign VGA_SYNC    = 1'b0;
  assign VGA_CLK     = vga_clk_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scanout_reader
// Purpose  : Directed self-checking bench for vga_scanout_reader. Horizontal
//            timing is full size. Vertical timing is shortened to 8 visible,
//            2 front, 2 sync and 2 back lines, so one frame is 14 lines.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scanout_reader;

  localparam int H_TOTAL    = 800;
  localparam int V_TOTAL    = 14;
  localparam int FRAME_CLKS = 2 * H_TOTAL * V_TOTAL;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] rd_addr;
  logic        rd_en;
  logic [2:0]  rd_data = 3'b000;
  logic [9:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK, frame_start;

  vga_scanout_reader #(
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK),
    .VGA_SYNC(VGA_SYNC), .VGA_CLK(VGA_CLK), .frame_start(frame_start)
  );

  always #10 clock = ~clock;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   fs_last = -1;
  int   fs_prev = -1;
  logic ram_mode = 1'b1;  // 1: every address returns 3'b111

  // Clock count since reset release; equals k right after the k-th edge.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(posedge clock) begin
    if (!reset && frame_start) begin
      fs_prev <= fs_last;
      fs_last <= cyc;
    end
  end

  // Synchronous-read RAM. Address 161 holds 3'b101. All others hold 3'b010.
  always @(posedge clock) begin
    if (rd_en) rd_data <= ram_mode ? 3'b111 : ((rd_addr == 15'd161) ? 3'b101 : 3'b010);
  end

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic goto(input int k);
    int guard = 0;
    while (cyc < k && guard < 100000) begin
      @(negedge clock);
      guard++;
    end
    chk("cycle_sync", cyc, k);
  endtask

  // Clock at which stage-0 outputs for pixel (h,v) of frame 0 are visible.
  function automatic int pos(input int h, input int v);
    return 2 * (v * H_TOTAL + h) + 2;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 0);
    chk({tag, "_hs_vs"}, {VGA_HS, VGA_VS}, 2'b11);
    chk({tag, "_blank"}, VGA_BLANK, 0);
    chk({tag, "_clk"}, VGA_CLK, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_sync"}, VGA_SYNC, 0);
  endtask

  int hs_cnt, hs_first, hs_last, blank_cnt, blank_last, vis_bad, leak, vs_low;

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    chk_reset_state("reset");
    reset = 1'b0;

    // First tick, first read, and first frame_start
    goto(1);
    chk("c1_rd_en", rd_en, 0);
    chk("c1_fs", frame_start, 0);
    goto(2);
    chk("c2_rd_en", rd_en, 1);
    chk("c2_rd_addr", rd_addr, 0);
    chk("c2_fs", frame_start, 1);
    chk("c2_vga_clk", VGA_CLK, 0);
    goto(3);
    chk("c3_rd_en", rd_en, 0);
    chk("c3_fs", frame_start, 0);
    chk("c3_vga_clk", VGA_CLK, 1);
    goto(4);
    chk("pix00_rgb", {VGA_R, VGA_G, VGA_B}, {30{1'b1}});
    chk("pix00_blank", VGA_BLANK, 1);

    // Horizontal replication on row 0: addresses 0,0,0,0,1,1,1,1
    for (int h = 1; h < 8; h++) begin
      goto(pos(h, 0));
      chk($sformatf("addr_h%0d", h), rd_addr, h / 4);
    end

    // Full line 1 with RAM forced to 3'b111
    hs_cnt = 0; hs_first = -1; hs_last = -1; blank_cnt = 0; blank_last = -1;
    vis_bad = 0; leak = 0; vs_low = 0;
    for (int h = 0; h < H_TOTAL; h++) begin
      goto(pos(h, 1) + 2);
      if (!VGA_HS) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = h;
        hs_last = h;
      end
      if (VGA_BLANK) begin
        blank_cnt++;
        blank_last = h;
        if ({VGA_R, VGA_G, VGA_B} != {30{1'b1}}) vis_bad++;
      end else if ({VGA_R, VGA_G, VGA_B} != 30'd0) begin
        leak++;
      end
      if (!VGA_VS) vs_low++;
    end
    chk("hs_low_ticks", hs_cnt, 96);
    chk("hs_first", hs_first, 656);
    chk("hs_last", hs_last, 751);
    chk("blank_ticks", blank_cnt, 640);
    chk("blank_last", blank_last, 639);
    chk("vis_colour", vis_bad, 0);
    chk("colour_leak", leak, 0);
    chk("vs_line1", vs_low, 0);
    ram_mode = 1'b0;

    // Pins for (3,4) still show address 160, then (4..7,4..7) show addr 161
    goto(pos(4, 4) + 1);
    chk("pix34_rg", {VGA_R, VGA_G}, {10'h000, 10'h3FF});
    for (int v = 4; v < 8; v++) begin
      for (int h = 4; h < 8; h++) begin
        goto(pos(h, v) + 2);
        chk($sformatf("pix%0d%0d_rgb", h, v), {VGA_R, VGA_G, VGA_B},
            {10'h3FF, 10'h000, 10'h3FF});
        chk($sformatf("pix%0d%0d_blank", h, v), VGA_BLANK, 1);
      end
    end

    // Last visible pixel and address hold at the start of blanking
    goto(pos(639, 7));
    chk("last_rd_en", rd_en, 1);
    chk("last_rd_addr", rd_addr, 319);
    goto(pos(639, 7) + 1);
    chk("last_rd_en_pulse", rd_en, 0);
    goto(pos(640, 7));
    chk("hblank_rd_en", rd_en, 0);
    chk("hblank_rd_addr", rd_addr, 319);
    ram_mode = 1'b1;

    // Vertical blanking lines: VS low on lines 10 and 11 only
    for (int v = 8; v < V_TOTAL; v++) begin
      goto(pos(100, v) + 2);
      chk($sformatf("vs_line%0d", v), VGA_VS, (v == 10 || v == 11) ? 0 : 1);
      chk($sformatf("blank_line%0d", v), VGA_BLANK, 0);
      chk($sformatf("rgb_line%0d", v), {VGA_R, VGA_G, VGA_B}, 0);
    end

    // Second frame_start is exactly one frame later
    goto(FRAME_CLKS + 1);
    chk("f2_fs_pre", frame_start, 0);
    goto(FRAME_CLKS + 2);
    chk("f2_fs", frame_start, 1);
    chk("f2_rd_addr", rd_addr, 0);
    goto(FRAME_CLKS + 3);
    chk("fs_last", fs_last, FRAME_CLKS + 2);
    chk("fs_prev", fs_prev, 2);

    // Reset mid-frame at (300,5)
    goto(FRAME_CLKS + pos(300, 5));
    chk("pre_rst_rd_en", rd_en, 1);
    chk("pre_rst_r", VGA_R, 10'h3FF);
    reset = 1'b1;
    @(negedge clock);
    chk_reset_state("midrst");
    reset = 1'b0;
    goto(1);
    chk("rst_c1_rd_en", rd_en, 0);
    goto(2);
    chk("rst_c2_rd_en", rd_en, 1);
    chk("rst_c2_rd_addr", rd_addr, 0);
    chk("rst_c2_fs", frame_start, 1);
    goto(4);
    chk("rst_pix00_blank", VGA_BLANK, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
